// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Imported by the top level and the per-channel holding register.
package demux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Round-robin successor with wrap at n-1; n need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/ready holding register for a single output channel.
// A load takes priority, so drain and refill may happen in the same cycle.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N valid/ready stream demultiplexer with addressed and
// round-robin target selection and out-of-range select detection.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [SEL_W-1:0]   rr_ptr,
    output logic               sel_err
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] target;
    logic             in_range;
    logic             tgt_busy;
    logic             accept;
    logic [N-1:0]     load;

    assign target   = (mode == MODE_RR) ? rr_ptr_q : in_sel;
    assign in_range = 32'(target) < N;

    // Explicit decode keeps out-of-range targets from indexing past the vectors.
    always_comb begin
        tgt_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (target == SEL_W'(k)) begin
                tgt_busy = out_valid[k] & ~out_ready[k];
            end
        end
    end

    assign in_ready = ~in_range | ~tgt_busy;
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept & in_range & (target == SEL_W'(k));
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        sel_err_d = accept & ~in_range;
        if (accept && in_range && mode == MODE_RR) begin
            rr_ptr_d = SEL_W'(next_ptr(32'(rr_ptr_q), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign rr_ptr  = rr_ptr_q;
    assign sel_err = sel_err_q;

endmodule
